// File: rtl/explosion_sprite_reader.sv
// Explosion sprite reader: prefetches one sprite row per hblank into a line buffer and
// serves registered palette indices during active video. Optional blink: EXPLOSION_FLICKER_EN.
module explosion_sprite_reader #(
    parameter int unsigned SPR_W       = 30,
    parameter int unsigned SPR_H       = 30,
    parameter int unsigned LIFE_FRAMES = 32,
    parameter logic [3:0]  TRANSPARENT = 4'h0,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        trigger,
    input  logic [9:0]  trig_x,
    input  logic [9:0]  trig_y,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  fetch_line,
    input  logic [9:0]  DrawX,
    output logic [18:0] ram_read_address,
    input  logic [3:0]  ram_data,
    output logic [3:0]  pixel_index,
    output logic        pixel_valid,
    output logic        active,
    output logic        busy
);

    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned EXT_W   = 11;
    localparam int unsigned ROW_W   = 10;
    localparam int unsigned LIFE_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned COL_W   = $clog2(SPR_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    // Row offset r*SPR_W as a sum of shifted copies of r, one per set bit of SPR_W.
    function automatic logic [ADDR_W-1:0] row_mul(input logic [ROW_W-1:0] r);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (((SPR_W >> i) & 32'd1) != 0) begin
                acc = acc + (ADDR_W'(r) << i);
            end
        end
        return acc;
    endfunction

    logic [COORD_W-1:0] pos_x_q;
    logic [COORD_W-1:0] pos_y_q;
    logic [LIFE_W-1:0]  life_q;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               busy_d;
    logic               row_ok_q, row_ok_d;
    logic               buf_we;
    logic [COL_W-1:0]   buf_wcol;
    logic [IDX_W-1:0]   linebuf [SPR_W];

    logic [EXT_W-1:0]   line_ext, y_ext, y_last, row_diff;
    logic               row_hit_c;
    logic [ADDR_W-1:0]  new_base_c;

    logic [EXT_W-1:0]   dx_ext, x_ext, x_last, col_diff;
    logic               in_x_c;
    logic [COL_W-1:0]   col_rd_c;
    logic [IDX_W-1:0]   rd_index_c;
    logic               flicker_c;
    logic               vis_c;

    // Explosion lifetime: trigger (re)loads, frame_start counts down to zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
            life_q  <= '0;
            active  <= 1'b0;
        end else if (trigger) begin
            pos_x_q <= trig_x;
            pos_y_q <= trig_y;
            life_q  <= LIFE_W'(LIFE_FRAMES);
            active  <= 1'b1;
        end else if (frame_start && active) begin
            life_q <= life_q - LIFE_W'(1);
            if (life_q == LIFE_W'(1)) begin
                active <= 1'b0;
            end
        end
    end

    // Vertical hit test and row base address, widened so pos_y near 1023 does not wrap.
    always_comb begin
        line_ext   = EXT_W'(fetch_line);
        y_ext      = EXT_W'(pos_y_q);
        y_last     = y_ext + EXT_W'(SPR_H - 1);
        row_hit_c  = active && (line_ext >= y_ext) && (line_ext <= y_last);
        row_diff   = line_ext - y_ext;
        new_base_c = ADDR_W'(BASE_ADDR) + row_mul(ROW_W'(row_diff));
    end

    // Fetch FSM next-state; a new line_start always pre-empts the current fetch.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        addr_d     = ram_read_address;
        busy_d     = busy;
        row_ok_d   = row_ok_q;
        buf_we     = 1'b0;
        buf_wcol   = col_q - COL_W'(1);

        if (line_start) begin
            row_ok_d = 1'b0;
            if (row_hit_c) begin
                state_d    = S_ISSUE;
                col_d      = '0;
                row_base_d = new_base_c;
                addr_d     = new_base_c;
                busy_d     = 1'b1;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_ISSUE: begin
                    // Data on ram_data belongs to the address issued one cycle earlier.
                    buf_we = (col_q != '0);
                    if (col_q == COL_W'(SPR_W - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        col_d  = col_q + COL_W'(1);
                        addr_d = row_base_q + ADDR_W'(col_q + COL_W'(1));
                    end
                end
                S_DRAIN: begin
                    buf_we   = 1'b1;
                    buf_wcol = COL_W'(SPR_W - 1);
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    row_ok_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q          <= S_IDLE;
            col_q            <= '0;
            row_base_q       <= ADDR_W'(BASE_ADDR);
            ram_read_address <= ADDR_W'(BASE_ADDR);
            busy             <= 1'b0;
            row_ok_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            row_base_q       <= row_base_d;
            ram_read_address <= addr_d;
            busy             <= busy_d;
            row_ok_q         <= row_ok_d;
        end
    end

    // Line buffer contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (buf_we) begin
            linebuf[buf_wcol] <= ram_data;
        end
    end

    // Horizontal hit test and buffer lookup for the current pixel.
    always_comb begin
        dx_ext     = EXT_W'(DrawX);
        x_ext      = EXT_W'(pos_x_q);
        x_last     = x_ext + EXT_W'(SPR_W - 1);
        in_x_c     = (dx_ext >= x_ext) && (dx_ext <= x_last);
        col_diff   = dx_ext - x_ext;
        col_rd_c   = in_x_c ? COL_W'(col_diff) : '0;
        rd_index_c = linebuf[col_rd_c];
`ifdef EXPLOSION_FLICKER_EN
        flicker_c  = active && (life_q <= LIFE_W'(8)) && life_q[0];
`else
        flicker_c  = 1'b0;
`endif
        vis_c      = row_ok_q && !busy && active && in_x_c &&
                     (rd_index_c != TRANSPARENT) && !flicker_c;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pixel_index <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= vis_c;
            pixel_index <= vis_c ? rd_index_c : '0;
        end
    end

endmodule

// File: tb/tb_explosion_sprite_reader.sv
// Directed self-checking bench for explosion_sprite_reader with a behavioural sprite RAM.
module tb_explosion_sprite_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        trigger;
    logic [9:0]  trig_x, trig_y;
    logic        frame_start, line_start;
    logic [9:0]  fetch_line, DrawX;
    logic [18:0] ram_read_address;
    logic [3:0]  ram_data;
    logic [3:0]  pixel_index;
    logic        pixel_valid, active, busy;

    logic [18:0] l_addr;
    logic [3:0]  l_index;
    logic        l_valid, l_active, l_busy;

    logic [3:0]  mem [0:1023];
    logic [18:0] addr_log [0:255];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) ram_data <= mem[ram_read_address[9:0]];

    explosion_sprite_reader u_dut (
        .Clk(Clk), .Reset(Reset), .trigger(trigger), .trig_x(trig_x), .trig_y(trig_y),
        .frame_start(frame_start), .line_start(line_start), .fetch_line(fetch_line),
        .DrawX(DrawX), .ram_read_address(ram_read_address), .ram_data(ram_data),
        .pixel_index(pixel_index), .pixel_valid(pixel_valid), .active(active), .busy(busy)
    );

    explosion_sprite_reader #(.LIFE_FRAMES(3)) u_life (
        .Clk(Clk), .Reset(Reset), .trigger(trigger), .trig_x(trig_x), .trig_y(trig_y),
        .frame_start(frame_start), .line_start(line_start), .fetch_line(fetch_line),
        .DrawX(DrawX), .ram_read_address(l_addr), .ram_data(ram_data),
        .pixel_index(l_index), .pixel_valid(l_valid), .active(l_active), .busy(l_busy)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_trigger(input logic [9:0] x, input logic [9:0] y);
        trigger = 1'b1; trig_x = x; trig_y = y;
        tick();
        trigger = 1'b0;
    endtask

    task automatic start_line(input logic [9:0] fl);
        line_start = 1'b1; fetch_line = fl;
        tick();
        line_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Issue a line_start and log the address bus for every cycle busy stays high.
    task automatic run_fetch(input logic [9:0] fl, output int n);
        start_line(fl);
        n = 0;
        while (busy && n < 200) begin
            addr_log[n] = ram_read_address;
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic bad;
        tick(); tick();
        checks++; if (ram_read_address !== 19'd0) $display("FAIL rst_addr: got %0d expected 0", ram_read_address);
        if (ram_read_address !== 19'd0) errors++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pixel_valid); end
        checks++; if (pixel_index !== 4'd0) begin errors++; $display("FAIL rst_index: got %0d expected 0", pixel_index); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b expected 0", active); end
        Reset = 1'b0;
        do_trigger(10'd100, 10'd200);
        start_line(10'd203);
        repeat (12) tick();
        checks++; if (ram_read_address !== 19'd102) begin errors++; $display("FAIL mid_issue_addr: got %0d expected 102", ram_read_address); end
        #3 Reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || pixel_valid !== 1'b0 || ram_read_address !== 19'd0 || active !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b valid=%b addr=%0d active=%b expected 0 0 0 0",
                     busy, pixel_valid, ram_read_address, active);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        start_line(10'd203);
        bad = 1'b0;
        repeat (40) begin
            if (ram_read_address !== 19'd0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got reads=%b expected 0", bad); end
    endtask

    task automatic test_main_fetch();
        int n;
        do_trigger(10'd100, 10'd200);
        run_fetch(10'd203, n);
        checks++; if (n != 31) begin errors++; $display("FAIL busy_cycles: got %0d expected 31", n); end
        for (int k = 0; k < 30; k++) begin
            checks++;
            if (addr_log[k] !== 19'(90 + k)) begin
                errors++;
                $display("FAIL row3_addr[%0d]: got %0d expected %0d", k, addr_log[k], 90 + k);
            end
        end
        DrawX = 10'd100; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd1) begin errors++; $display("FAIL draw_x100: got v=%b i=%0d expected v=1 i=1", pixel_valid, pixel_index); end
        DrawX = 10'd129; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd15) begin errors++; $display("FAIL draw_x129: got v=%b i=%0d expected v=1 i=15", pixel_valid, pixel_index); end
        DrawX = 10'd130; tick();
        checks++; if (pixel_valid !== 1'b0 || pixel_index !== 4'd0) begin errors++; $display("FAIL draw_x130: got v=%b i=%0d expected v=0 i=0", pixel_valid, pixel_index); end
        DrawX = 10'd99; tick();
        checks++; if (pixel_valid !== 1'b0 || pixel_index !== 4'd0) begin errors++; $display("FAIL draw_x99: got v=%b i=%0d expected v=0 i=0", pixel_valid, pixel_index); end
    endtask

    task automatic test_out_of_range();
        logic [18:0] a0;
        logic        bad;
        int          n;
        logic [9:0]  lines [2];
        lines[0] = 10'd199;
        lines[1] = 10'd230;
        for (int j = 0; j < 2; j++) begin
            a0 = ram_read_address;
            start_line(lines[j]);
            bad = 1'b0;
            repeat (35) begin
                if (busy !== 1'b0 || ram_read_address !== a0) bad = 1'b1;
                tick();
            end
            checks++; if (bad !== 1'b0) begin errors++; $display("FAIL oor_line%0d: got reads=%b expected 0", lines[j], bad); end
            DrawX = 10'd100; tick();
            checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL oor_valid%0d: got %b expected 0", lines[j], pixel_valid); end
        end
        run_fetch(10'd229, n);
        checks++; if (n != 31 || addr_log[0] !== 19'd870 || addr_log[29] !== 19'd899) begin
            errors++;
            $display("FAIL row29: got n=%0d first=%0d last=%0d expected 31 870 899", n, addr_log[0], addr_log[29]);
        end
    endtask

    task automatic test_no_wrap();
        int n;
        do_trigger(10'd100, 10'd1000);
        run_fetch(10'd1005, n);
        checks++; if (n != 31 || addr_log[0] !== 19'd150 || addr_log[29] !== 19'd179) begin
            errors++;
            $display("FAIL no_wrap: got n=%0d first=%0d last=%0d expected 31 150 179", n, addr_log[0], addr_log[29]);
        end
        DrawX = 10'd100; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd1) begin errors++; $display("FAIL no_wrap_draw: got v=%b i=%0d expected v=1 i=1", pixel_valid, pixel_index); end
    endtask

    task automatic test_restart();
        int  n;
        logic bad;
        for (int c = 0; c < 30; c++) mem[120 + c] = 4'(15 - (c % 15));
        do_trigger(10'd100, 10'd200);
        start_line(10'd203);
        repeat (9) tick();
        checks++; if (ram_read_address !== 19'd99) begin errors++; $display("FAIL restart_pre: got %0d expected 99", ram_read_address); end
        line_start = 1'b1; fetch_line = 10'd204;
        tick();
        line_start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            addr_log[n] = ram_read_address;
            n++;
            tick();
        end
        checks++; if (n != 31) begin errors++; $display("FAIL restart_busy: got %0d expected 31", n); end
        bad = 1'b0;
        for (int k = 0; k < 30; k++) if (addr_log[k] !== 19'(120 + k)) bad = 1'b1;
        checks++; if (bad !== 1'b0 || addr_log[0] !== 19'd120) begin errors++; $display("FAIL restart_addr: got first=%0d expected 120", addr_log[0]); end
        DrawX = 10'd100; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd15) begin errors++; $display("FAIL restart_c0: got v=%b i=%0d expected v=1 i=15", pixel_valid, pixel_index); end
        DrawX = 10'd108; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd7) begin errors++; $display("FAIL restart_c8: got v=%b i=%0d expected v=1 i=7", pixel_valid, pixel_index); end
        DrawX = 10'd129; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd1) begin errors++; $display("FAIL restart_c29: got v=%b i=%0d expected v=1 i=1", pixel_valid, pixel_index); end
    endtask

    task automatic test_transparent();
        int n;
        mem[210] = 4'h0;
        run_fetch(10'd207, n);
        checks++; if (n != 31) begin errors++; $display("FAIL transp_busy: got %0d expected 31", n); end
        DrawX = 10'd100; tick();
        checks++; if (pixel_valid !== 1'b0 || pixel_index !== 4'd0) begin errors++; $display("FAIL transp_c0: got v=%b i=%0d expected v=0 i=0", pixel_valid, pixel_index); end
        DrawX = 10'd101; tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd2) begin errors++; $display("FAIL transp_c1: got v=%b i=%0d expected v=1 i=2", pixel_valid, pixel_index); end
    endtask

    task automatic test_life();
        logic exp_act [3];
        exp_act[0] = 1'b1; exp_act[1] = 1'b1; exp_act[2] = 1'b0;
        do_trigger(10'd100, 10'd200);
        checks++; if (l_active !== 1'b1) begin errors++; $display("FAIL life_trig: got %b expected 1", l_active); end
        for (int f = 0; f < 3; f++) begin
            pulse_frame();
            checks++; if (l_active !== exp_act[f]) begin errors++; $display("FAIL life_frame%0d: got %b expected %b", f, l_active, exp_act[f]); end
        end
        do_trigger(10'd100, 10'd200);
        pulse_frame();
        trigger = 1'b1; frame_start = 1'b1;
        tick();
        trigger = 1'b0; frame_start = 1'b0;
        checks++; if (l_active !== 1'b1) begin errors++; $display("FAIL life_coincide: got %b expected 1", l_active); end
        for (int f = 0; f < 3; f++) begin
            pulse_frame();
            checks++; if (l_active !== exp_act[f]) begin errors++; $display("FAIL life_reload%0d: got %b expected %b", f, l_active, exp_act[f]); end
        end
    endtask

    task automatic test_visibility();
        int   n;
        int   life;
        logic exp_v;
        do_trigger(10'd100, 10'd200);
        for (int f = 0; f < 32; f++) begin
            life = 32 - f;
`ifdef EXPLOSION_FLICKER_EN
            exp_v = !(life <= 8 && (life % 2) == 1);
`else
            exp_v = 1'b1;
`endif
            run_fetch(10'd203, n);
            DrawX = 10'd100; tick();
            checks++;
            if (pixel_valid !== exp_v || pixel_index !== (exp_v ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL vis_life%0d: got v=%b i=%0d expected v=%b", life, pixel_valid, pixel_index, exp_v);
            end
            pulse_frame();
        end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL vis_expire: got %b expected 0", active); end
        tick();
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL vis_after_expire: got %b expected 0", pixel_valid); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 4'((a % 15) + 1);
        Reset = 1'b1; trigger = 1'b0; trig_x = '0; trig_y = '0;
        frame_start = 1'b0; line_start = 1'b0; fetch_line = '0; DrawX = '0;
        #1;
        test_reset();
        test_main_fetch();
        test_out_of_range();
        test_no_wrap();
        test_restart();
        test_transparent();
        test_life();
        test_visibility();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
